multdiv_seq: RTL
================

MULTDIV_SEQ -- requirements
Module: multdiv_seq

Interface
REQ-001 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port ctrl_reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port data_operandA, input, 32, operand A (multiplicand / dividend), driven from regfile data_readRegA.
REQ-004 SHALL have port data_operandB, input, 32, operand B (multiplier / divisor), driven from regfile data_readRegB.
REQ-005 SHALL have port ctrl_MULT, input, 1, one-cycle start pulse for a signed multiply.
REQ-006 SHALL have port ctrl_DIV, input, 1, one-cycle start pulse for a signed divide.
REQ-007 SHALL have port data_result, output, 32, low 32 bits of the product, or the quotient.
REQ-008 SHALL have port data_exception, output, 1, overflow, divide-by-zero or divide overflow flag.
REQ-009 SHALL have port data_resultRDY, output, 1, one-cycle pulse marking data_result/data_exception valid.
REQ-010 SHALL have port busy, output, 1, high while an operation is in progress.

Function
REQ-011 SHALL implement a four-state FSM: IDLE, MUL, DIV, DONE.
REQ-012 SHALL sample data_operandA/data_operandB into internal registers on the start edge; operand inputs are ignored afterwards.
REQ-013 SHALL transition IDLE/DONE -> MUL on ctrl_MULT=1, and -> DIV on ctrl_DIV=1 with ctrl_MULT=0.
REQ-014 SHALL give ctrl_MULT priority when ctrl_MULT and ctrl_DIV are both high in the same cycle.
REQ-015 SHALL, on a start pulse while in MUL or DIV, abort the current operation and restart with the new operands and opcode; no resultRDY for the aborted operation.
REQ-016 SHALL use a 5-bit iteration counter, cleared on start, processing one bit per cycle for 32 cycles (counter 0..31).
REQ-017 SHALL multiply by iterative shift-add (or Booth radix-2) on 64-bit signed partial product; data_result = product[31:0].
REQ-018 SHALL set data_exception on multiply when product[63:31] is not all-zeros or all-ones (signed 32-bit overflow).
REQ-019 SHALL divide by restoring/non-restoring unsigned division on magnitudes, then negate the quotient when operand signs differ (truncate toward zero); remainder is discarded.
REQ-020 SHALL, on divisor 0, produce data_result=0x00000000 and data_exception=1.
REQ-021 SHALL, on 0x80000000 / 0xFFFFFFFF, produce data_result=0x80000000 and data_exception=1.
REQ-022 SHALL, for divide-by-zero and divide overflow, still take the full latency (no early completion).
REQ-023 SHALL enter DONE after the 32nd iteration; in DONE, data_resultRDY=1 for exactly one cycle; DONE -> IDLE next cycle unless a new start is present.
REQ-024 SHALL have fixed latency: start sampled at edge T -> data_resultRDY high during cycle T+33.
REQ-025 SHALL hold data_result and data_exception stable from the resultRDY cycle until the next start edge.
REQ-026 SHALL drive busy=1 in MUL and DIV, 0 in IDLE and DONE.
REQ-027 SHALL accept a start in the DONE cycle (back-to-back operation, no bubble).

Reset
REQ-028 SHALL, on ctrl_reset=1, immediately (without clock) force state=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0, internal operand registers=0.
REQ-029 SHALL, on reset asserted mid-operation, discard the operation; no resultRDY is produced after release.
REQ-030 SHALL ignore ctrl_MULT/ctrl_DIV while ctrl_reset=1; first start accepted on the first edge after release.

Verification
REQ-031 SHALL pass: MULT, A=7, B=-6 -> at T+33 resultRDY=1, result=0xFFFFFFD6, exception=0.
REQ-032 SHALL pass: MULT, A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1; and A=0x40000000, B=2 -> result=0x80000000, exception=1.
REQ-033 SHALL pass: DIV, A=-7, B=2 -> result=0xFFFFFFFD (-3), exception=0; DIV A=100, B=0 -> result=0, exception=1 at T+33.
REQ-034 SHALL pass: DIV A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=1.
REQ-035 SHALL pass: MULT 3x4 started, ctrl_DIV 20/5 pulsed 10 cycles later -> single resultRDY at restart+33, result=4; no pulse for the aborted multiply.
REQ-036 SHALL pass: ctrl_reset pulsed asynchronously at cycle 15 of a multiply -> outputs 0 immediately, busy=0, no resultRDY for 40 cycles afterwards.

Source files
------------

// File: rtl/multdiv_seq.sv
// Sequential signed 32-bit multiply / divide unit: one bit per cycle, fixed
// 33-cycle latency from start edge to the one-cycle resultRDY pulse.
module multdiv_seq (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic        fin;
  logic [31:0] opa, opb;
  logic [63:0] acc, mcand;

  logic        start;
  logic [31:0] mag_a_in, mag_b, quo_s;
  logic [32:0] trial, diff;
  logic        mul_ovf;

  assign start = ctrl_MULT | ctrl_DIV;

  // Divide: acc[63:32] is the partial remainder, acc[31:0] shifts the dividend
  // magnitude out from the top while quotient bits enter at the bottom.
  assign mag_a_in = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
  assign mag_b    = opb[31] ? (~opb + 32'd1) : opb;
  assign trial    = {acc[63:32], acc[31]};
  assign diff     = trial - {1'b0, mag_b};
  assign quo_s    = (opa[31] ^ opb[31]) ? (~acc[31:0] + 32'd1) : acc[31:0];
  assign mul_ovf  = !((&acc[63:31]) || !(|acc[63:31]));

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    data_resultRDY = 1'b0;
    busy           = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = ctrl_MULT ? MUL : DIV;
      MUL, DIV: begin
        busy = 1'b1;
        if (start)    state_nxt = ctrl_MULT ? MUL : DIV;
        else if (fin) state_nxt = DONE;
      end
      DONE: begin
        data_resultRDY = 1'b1;
        if (start) state_nxt = ctrl_MULT ? MUL : DIV;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      cnt            <= 5'd0;
      fin            <= 1'b0;
      opa            <= 32'd0;
      opb            <= 32'd0;
      acc            <= 64'd0;
      mcand          <= 64'd0;
      data_result    <= 32'd0;
      data_exception <= 1'b0;
    end else if (start) begin
      opa   <= data_operandA;
      opb   <= data_operandB;
      cnt   <= 5'd0;
      fin   <= 1'b0;
      acc   <= ctrl_MULT ? 64'd0 : {32'd0, mag_a_in};
      mcand <= {{32{data_operandA[31]}}, data_operandA};
    end else if ((state == MUL || state == DIV) && !fin) begin
      cnt <= cnt + 5'd1;
      if (cnt == 5'd31) fin <= 1'b1;
      if (state == MUL) begin
        // Multiplier bit 31 carries weight -2^31 in two's complement.
        if (opb[cnt]) acc <= (cnt == 5'd31) ? (acc - mcand) : (acc + mcand);
        mcand <= mcand << 1;
      end else begin
        if (!diff[32]) acc <= {diff[31:0], acc[30:0], 1'b1};
        else           acc <= {trial[31:0], acc[30:0], 1'b0};
      end
    end else if ((state == MUL || state == DIV) && fin) begin
      if (state == MUL) begin
        data_result    <= acc[31:0];
        data_exception <= mul_ovf;
      end else if (opb == 32'd0) begin
        data_result    <= 32'd0;
        data_exception <= 1'b1;
      end else begin
        data_result    <= quo_s;
        data_exception <= (opa == 32'h8000_0000) && (opb == 32'hFFFF_FFFF);
      end
    end
  end

endmodule
